// File: rtl/gf_syndrome_calc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ecc_pkg
//  Purpose  : Shared GF(2^8) arithmetic, field defaults and the FSM state type
//             for the Reed-Solomon syndrome calculator.
//  Contents : c_PRIM_POLY     - default field polynomial x^8+x^4+x^3+x^2+1
//             state_t         - IDLE / ACCUM / DONE state encoding
//             gf_mul()        - GF(2^8) multiply reduced by a given polynomial
//             gf_alpha_pow()  - alpha^j, usable as a constant function
//  Revision : 1.0 - initial release
// ============================================================================
package ecc_pkg;

   localparam logic [8:0] c_PRIM_POLY = 9'h11D;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Shift-and-add multiply; the partial multiplicand is reduced each time
   // its top bit would overflow out of the field.
   function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                         input logic [7:0] b,
                                         input logic [8:0] poly);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         if (x[7]) x = {x[6:0], 1'b0} ^ poly[7:0];
         else      x = {x[6:0], 1'b0};
      end
      return p;
   endfunction

   function automatic logic [7:0] gf_alpha_pow(input int j,
                                               input logic [8:0] poly);
      logic [7:0] p;
      p = 8'h01;
      for (int k = 0; k < j; k++) p = gf_mul(p, 8'h02, poly);
      return p;
   endfunction

endpackage
`default_nettype wire

// File: rtl/gf_syndrome_calc_if.sv
`default_nettype none
// ============================================================================
//  Module   : gf_syndrome_calc_if
//  Purpose  : Byte-stream and result bundle of the syndrome calculator.
//  Signals  : start, dataValid, dataIn            - stream into the block
//             dataReady, busy, done, errDetect,
//             syndrome[16*T-1:0]                  - status and results
//  Modports : master - stream source / result consumer
//             slave  - the syndrome calculator
//  Revision : 1.0 - initial release
// ============================================================================
interface gf_syndrome_calc_if #(
   parameter int T = 2
);
   logic            start;
   logic            dataValid;
   logic [7:0]      dataIn;
   logic            dataReady;
   logic            busy;
   logic            done;
   logic            errDetect;
   logic [16*T-1:0] syndrome;

   modport master (
      output start, dataValid, dataIn,
      input  dataReady, busy, done, errDetect, syndrome
   );

   modport slave (
      input  start, dataValid, dataIn,
      output dataReady, busy, done, errDetect, syndrome
   );
endinterface
`default_nettype wire

// File: rtl/gf_syndrome_calc_const_mul.sv
`default_nettype none
// ============================================================================
//  Module   : gf_const_mul
//  Purpose  : Multiply an 8-bit GF(2^8) element by an elaboration-time
//             constant. Reduces to a pure XOR network.
//  Ports    : i_a [7:0] - variable operand
//             o_p [7:0] - i_a * CONST
//  Revision : 1.0 - initial release
// ============================================================================
module gf_const_mul
   import ecc_pkg::*;
#(
   parameter logic [7:0] CONST     = 8'h02,
   parameter logic [8:0] PRIM_POLY = c_PRIM_POLY
) (
   input  wire logic [7:0] i_a,
   output logic      [7:0] o_p
);

   // Column k of the multiply matrix is alpha^k * CONST, a constant; each set
   // bit of i_a selects its column into the XOR sum.
   always_comb begin
      o_p = 8'h00;
      for (int k = 0; k < 8; k++) begin
         if (i_a[k]) o_p = o_p ^ gf_mul(8'(1 << k), CONST, PRIM_POLY);
      end
   end

endmodule
`default_nettype wire

// File: rtl/gf_syndrome_calc.sv
`default_nettype none
// ============================================================================
//  Module   : gf_syndrome_calc
//  Purpose  : Streams a CW_BYTES-byte Reed-Solomon codeword (highest-degree
//             coefficient first) and computes the 2*T syndromes
//             S_j = C(alpha^j), j = 1..2T, by Horner evaluation.
//  Ports    : clk   - rising-edge clock
//             reset - synchronous active-high reset
//             bus   - gf_syndrome_calc_if.slave (start, dataValid, dataIn,
//                     dataReady, busy, done, errDetect, syndrome)
//  Revision : 1.0 - initial release
// ============================================================================
module gf_syndrome_calc
   import ecc_pkg::*;
#(
   parameter int         T         = 2,
   parameter int         CW_BYTES  = 528,
   parameter logic [8:0] PRIM_POLY = c_PRIM_POLY
) (
   input wire logic           clk,
   input wire logic           reset,
   gf_syndrome_calc_if.slave  bus
);

   localparam int                 c_CNT_W = $clog2(CW_BYTES);
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CW_BYTES - 1);

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic [c_CNT_W-1:0]        r_byte_cnt;
   logic [2*T-1:0][7:0]       r_synd;
   logic [2*T-1:0][7:0]       w_synd_mul;
   logic                      w_clear;
   logic                      w_accept;
   logic                      w_last;

   assign w_last = (r_byte_cnt == c_LAST);

   // One constant multiplier per syndrome: S_j * alpha^j.
   generate
      for (genvar j = 0; j < 2*T; j++) begin : g_synd
         gf_const_mul #(
            .CONST     (gf_alpha_pow(j + 1, PRIM_POLY)),
            .PRIM_POLY (PRIM_POLY)
         ) u_mul (
            .i_a (r_synd[j]),
            .o_p (w_synd_mul[j])
         );
      end
   endgenerate

   always_comb begin
      w_state_nxt = r_state;
      w_clear     = 1'b0;
      w_accept    = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               w_state_nxt = ST_ACCUM;
               w_clear     = 1'b1;
            end
         end
         ST_ACCUM: begin
            // A restart wins over a byte presented in the same cycle.
            if (bus.start) begin
               w_clear = 1'b1;
            end else if (bus.dataValid) begin
               w_accept = 1'b1;
               if (w_last) w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            if (bus.start) begin
               w_state_nxt = ST_ACCUM;
               w_clear     = 1'b1;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_byte_cnt <= '0;
         r_synd     <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_clear) begin
            r_byte_cnt <= '0;
            r_synd     <= '0;
         end else if (w_accept) begin
            // Counter parks at the last index so it can never wrap.
            if (!w_last) r_byte_cnt <= r_byte_cnt + c_CNT_W'(1);
            for (int j = 0; j < 2*T; j++) begin
               r_synd[j] <= w_synd_mul[j] ^ bus.dataIn;
            end
         end
      end
   end

   assign bus.dataReady = (r_state == ST_ACCUM);
   assign bus.busy      = (r_state != ST_IDLE) | bus.start;
   assign bus.done      = (r_state == ST_DONE);
   assign bus.errDetect = |r_synd;
   assign bus.syndrome  = r_synd;

endmodule
`default_nettype wire

// File: tb/tb_gf_syndrome_calc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gf_syndrome_calc
//  Purpose  : Self-checking bench for gf_syndrome_calc (T=2, CW_BYTES=528).
//             Expected syndromes are queued when a frame is launched and
//             compared when done pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gf_syndrome_calc;

   localparam int c_T  = 2;
   localparam int c_CW = 528;

   typedef struct packed {
      logic [31:0] synd;
      logic        err;
   } exp_t;

   typedef struct {
      int          pos_a;
      logic [7:0]  val_a;
      int          pos_b;
      logic [7:0]  val_b;
      bit          gap;
      logic [31:0] exp_synd;
      logic        exp_err;
   } vec_t;

   logic clk;
   logic reset;

   gf_syndrome_calc_if #(.T(c_T)) bus ();

   gf_syndrome_calc #(
      .T         (c_T),
      .CW_BYTES  (c_CW),
      .PRIM_POLY (9'h11D)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         errors = 0;
   int         checks = 0;
   int         done_cnt = 0;
   exp_t       exp_q[$];
   logic [7:0] fb[c_CW];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference GF(2^8) multiply, poly 0x11D.
   function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p ^= x;
         x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1D) : {x[6:0], 1'b0};
      end
      return p;
   endfunction

   function automatic logic [31:0] tb_synd();
      logic [31:0] r = '0;
      logic [7:0]  aj = 8'h01;
      logic [7:0]  s;
      for (int j = 0; j < 2*c_T; j++) begin
         aj = tb_mul(aj, 8'h02);
         s  = 8'h00;
         for (int i = 0; i < c_CW; i++) s = tb_mul(s, aj) ^ fb[i];
         r[8*j +: 8] = s;
      end
      return r;
   endfunction

   task automatic push_exp(input logic [31:0] s);
      exp_t e;
      e.synd = s;
      e.err  = |s;
      exp_q.push_back(e);
   endtask

   task automatic pulse_start(input logic dv, input logic [7:0] d);
      bus.start     = 1'b1;
      bus.dataValid = dv;
      bus.dataIn    = d;
      @(posedge clk); #1;
      bus.start     = 1'b0;
      bus.dataValid = 1'b0;
   endtask

   task automatic send_range(input int first, input int last, input bit gap);
      for (int i = first; i <= last; i++) begin
         bus.dataValid = 1'b1;
         bus.dataIn    = fb[i];
         @(posedge clk); #1;
         bus.dataValid = 1'b0;
         if (gap && i != last) begin
            bus.dataIn = 8'hFF;
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_synd"},  bus.syndrome,  32'h0);
      chk({tag, "_err"},   bus.errDetect, 32'h0);
      chk({tag, "_busy"},  bus.busy,      32'h0);
      chk({tag, "_ready"}, bus.dataReady, 32'h0);
      chk({tag, "_done"},  bus.done,      32'h0);
   endtask

   // Scoreboard side: compare at each done pulse.
   always @(negedge clk) begin
      if (bus.done === 1'b1) begin
         exp_t e;
         done_cnt++;
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'h1, 32'h0);
         end else begin
            e = exp_q.pop_front();
            chk("sb_syndrome",  bus.syndrome,  e.synd);
            chk("sb_errDetect", bus.errDetect, e.err);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   vec_t vecs[6];
   int   dc0;

   initial begin
      vecs[0] = '{-1, 8'h00, -1, 8'h00, 1'b0, 32'h00000000, 1'b0};
      vecs[1] = '{527, 8'h01, -1, 8'h00, 1'b0, 32'h01010101, 1'b1};
      vecs[2] = '{526, 8'h01, -1, 8'h00, 1'b0, 32'h10080402, 1'b1};
      vecs[3] = '{526, 8'h01, -1, 8'h00, 1'b1, 32'h10080402, 1'b1};
      vecs[4] = '{525, 8'h01, -1, 8'h00, 1'b0, 32'h1D401004, 1'b1};
      vecs[5] = '{526, 8'h01, 527, 8'hA5, 1'b0, 32'hB5ADA1A7, 1'b1};

      reset         = 1'b1;
      bus.start     = 1'b0;
      bus.dataValid = 1'b0;
      bus.dataIn    = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      reset = 1'b0;
      @(posedge clk); #1;

      // Table-driven frames.
      foreach (vecs[v]) begin
         for (int i = 0; i < c_CW; i++) fb[i] = 8'h00;
         if (vecs[v].pos_a >= 0) fb[vecs[v].pos_a] = vecs[v].val_a;
         if (vecs[v].pos_b >= 0) fb[vecs[v].pos_b] = vecs[v].val_b;
         push_exp(vecs[v].exp_synd);
         chk("exp_err_table", {31'h0, vecs[v].exp_err}, {31'h0, |vecs[v].exp_synd});
         pulse_start(1'b0, 8'h00);
         chk("ready_in_accum", bus.dataReady, 32'h1);
         send_range(0, c_CW - 1, vecs[v].gap);
         chk("done_latency", bus.done, 32'h1);
         @(posedge clk); #1;
         chk("done_one_cycle", bus.done, 32'h0);
      end

      // Results hold in IDLE; stray dataValid ignored.
      bus.dataValid = 1'b1;
      bus.dataIn    = 8'h77;
      repeat (4) @(posedge clk);
      #1;
      bus.dataValid = 1'b0;
      chk("hold_idle_synd", bus.syndrome, 32'hB5ADA1A7);
      chk("hold_idle_busy", bus.busy, 32'h0);

      // Restart at byte 100 with a byte presented alongside start.
      for (int i = 0; i < c_CW; i++) fb[i] = 8'h5A;
      dc0 = done_cnt;
      pulse_start(1'b0, 8'h00);
      send_range(0, 99, 1'b0);
      for (int i = 0; i < c_CW; i++) fb[i] = 8'h00;
      push_exp(32'h0);
      pulse_start(1'b1, 8'hFF);
      chk("restart_cleared", bus.syndrome, 32'h0);
      send_range(0, c_CW - 1, 1'b0);
      chk("restart_latency", bus.done, 32'h1);
      @(posedge clk); #1;
      chk("restart_one_done", done_cnt, dc0 + 1);

      // Reset in the middle of a frame.
      for (int i = 0; i < c_CW; i++) fb[i] = 8'h33;
      pulse_start(1'b0, 8'h00);
      send_range(0, 299, 1'b0);
      dc0 = done_cnt;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check_idle_outputs("midreset");
      repeat (5) @(posedge clk);
      #1;
      chk("midreset_no_done", done_cnt, dc0);

      // Random frame after reset, then a start taken in the DONE cycle.
      for (int i = 0; i < c_CW; i++) fb[i] = 8'($urandom);
      push_exp(tb_synd());
      pulse_start(1'b0, 8'h00);
      send_range(0, c_CW - 1, 1'b0);
      chk("rand_latency", bus.done, 32'h1);
      for (int i = 0; i < c_CW; i++) fb[i] = 8'h00;
      fb[527] = 8'h3C;
      push_exp(32'h3C3C3C3C);
      pulse_start(1'b0, 8'h00);
      chk("b2b_busy", bus.busy, 32'h1);
      send_range(0, c_CW - 1, 1'b0);
      chk("b2b_latency", bus.done, 32'h1);

      repeat (3) @(posedge clk);
      #1;
      chk("sb_queue_empty", exp_q.size(), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
